channel_accum: RTL and testbench
================================

# channel_accum

Downstream stage of the per-channel dot-product unit. It consumes the stream of signed partial sums (one `data_len`-bit word per valid pulse) and accumulates a programmed number of partial sums for one output pixel. It then adds the channel bias, optionally applies ReLU, saturates back to `data_len` bits and presents the result on a valid/ready handshake toward the output feature-map buffer.

## Interface
Parameters:
- DW, default `data_len` (18): word width; signed fixed point with FRAC fractional bits.
- FRAC, default 10: fractional bits. Informational only; the arithmetic is scale-free.
- GW, default 4: width of the group-count input. The accumulator guard width equals GW.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- start  in  1  begins one output pixel; sampled only in IDLE.
- n_groups  in  GW  number of partial sums to accumulate; sampled with start.
- bias  in  DW  signed bias; sampled with start.
- relu_en  in  1  enables ReLU; sampled with start.
- in_valid  in  1  partial-sum strobe, driven by the dot unit's valid.
- in_data  in  DW  signed partial sum, driven by the dot unit's q.
- out_ready  in  1  downstream accepts out_data.
- out_valid  out  1  result available.
- out_data  out  DW  saturated result.
- out_sat  out  1  saturation occurred for this result; qualified by out_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- Accumulator acc is signed and DW+GW bits wide. Operands are sign-extended to that width, so no overflow is possible for up to 2^GW−1 terms plus the bias.
- The FSM has four states: IDLE, ACCUM, FINISH, OUT.
- IDLE:
  - If start=1 and n_groups≠0: acc←sext(bias), cnt←n_groups, latch relu_en, go to ACCUM.
  - If start=1 and n_groups=0: ignore start and stay in IDLE.
  - in_valid is ignored in IDLE.
- ACCUM:
  - On each in_valid=1: acc←acc+sext(in_data), cnt←cnt−1.
  - When cnt reaches 0 on that edge, go to FINISH.
  - Cycles with in_valid=0 are wait cycles; no timeout.
- FINISH (one cycle):
  - r = (relu and acc<0) ? 0 : acc.
  - If r > 2^(DW−1)−1, out_data = 2^(DW−1)−1. If r < −2^(DW−1), out_data = −2^(DW−1). Otherwise out_data = r[DW−1:0].
  - out_sat = 1 iff clamping occurred. ReLU zeroing alone is not saturation.
  - Go to OUT.
- OUT:
  - out_valid=1; out_data and out_sat are held stable.
  - When out_valid and out_ready are both 1 on an edge, go to IDLE.
- start outside IDLE is ignored. in_valid outside ACCUM is dropped; the upstream stage is sequenced so that this does not occur.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, busy=0, state=IDLE, acc=0, cnt=0.
- Reset asserted mid-operation aborts the pixel immediately; no output is produced.
- start is sampled at edge E0; busy=1 from E0. The first in_valid accepted is at the edge after E0. A start and in_valid in the same IDLE cycle: the in_valid is dropped.
- The last partial sum is sampled at edge Ek. FINISH occupies the cycle after Ek. out_valid=1 after edge Ek+1, i.e. 2-cycle latency.
- With out_ready held at 1, out_valid is a single-cycle pulse. IDLE is reached at Ek+2, and a new start is accepted at Ek+2 at the earliest.
- out_ready is a don't-care when out_valid=0.
- Back-to-back in_valid on every cycle is supported; throughput is one partial sum per clock.

## Test plan
- Basic sum: bias=0x00400 (1.0), n_groups=3, in_data 0x00400, 0x00800, 0xFFC00 on consecutive cycles, relu_en=0 -> out_data=0x00C00 (3.0), out_sat=0, out_valid exactly 2 cycles after the third in_valid.
- ReLU: bias=0, n_groups=2, in_data 0xFF000, 0x00400 -> with relu_en=1, out_data=0; with relu_en=0, out_data=0xFF400. out_sat=0 in both runs.
- Saturation: n_groups=4, each in_data=0x1FFFF, bias=0x1FFFF -> out_data=0x1FFFF, out_sat=1. Repeat with each in_data=0x20000 and bias=0x20000 -> out_data=0x20000, out_sat=1.
- Gapped input and backpressure: n_groups=2, in_valid gaps of 3 cycles, out_ready=0 for 5 cycles -> out_valid/out_data held stable; start pulses during busy are ignored; IDLE is reached on the edge where out_ready=1.
- Boundary: start with n_groups=0 -> busy stays 0. in_valid in IDLE is ignored. The maximum of 15 groups of 0x00400 with bias=0 gives out_data=0x03C00.
- Reset mid-ACCUM after 2 of 3 partial sums -> all outputs are 0 at once. A fresh pixel after reset (bias=0, one in_data=0x00400) gives 0x00400, with no residue from the aborted pixel.

Source files
------------

// File: rtl/channel_accum.sv
// channel_accum: accumulates n_groups signed partial sums plus bias, optional ReLU,
// saturates to DW bits and hands the result downstream on a valid/ready handshake.
module channel_accum #(
    parameter int DW   = 18,
    parameter int FRAC = 10,
    parameter int GW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [GW-1:0] n_groups,
    input  logic [DW-1:0] bias,
    input  logic          relu_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sat,
    output logic          busy
);
    localparam int AW = DW + GW;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] acc;
    logic [GW-1:0] cnt;
    logic          relu;
    logic [AW-1:0] r;
    logic [GW:0]   upper;
    logic          sat;
    logic [DW-1:0] sat_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && n_groups != '0) ? ACCUM : IDLE;
            ACCUM:   state_nx = (in_valid && cnt == GW'(1)) ? FINISH : ACCUM;
            FINISH:  state_nx = OUT;
            default: state_nx = out_ready ? IDLE : OUT;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        out_valid = state == OUT;
    end

    // The result fits in DW bits only when the bits above the DW-bit sign are a pure sign extension.
    always_comb begin
        r        = (relu && acc[AW-1]) ? '0 : acc;
        upper    = r[AW-1:DW-1];
        sat      = !((&upper) || !(|upper));
        sat_data = !sat ? r[DW-1:0] : r[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            relu     <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (state == IDLE && start && n_groups != '0) begin
                acc  <= {{GW{bias[DW-1]}}, bias};
                cnt  <= n_groups;
                relu <= relu_en;
            end
            if (state == ACCUM && in_valid) begin
                acc <= acc + {{GW{in_data[DW-1]}}, in_data};
                cnt <= cnt - GW'(1);
            end
            if (state == FINISH) begin
                out_data <= sat_data;
                out_sat  <= sat;
            end
        end
    end
endmodule

// File: tb/tb_channel_accum.sv
// tb_channel_accum: directed vectors with hand-computed results for channel_accum.
module tb_channel_accum;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  n_groups = '0;
    logic [17:0] bias = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [17:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_sat;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    logic [17:0] held;

    channel_accum dut (
        .clk(clk), .rst(rst), .start(start), .n_groups(n_groups), .bias(bias),
        .relu_en(relu_en), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [17:0] b, input logic [3:0] n, input logic relu);
        start = 1'b1;
        bias = b;
        n_groups = n;
        relu_en = relu;
        tick;
        start = 1'b0;
    endtask

    task automatic feed(input logic [17:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) tick;
        check(tag, out_valid, 1);
    endtask

    task automatic result(input string tag, input logic [17:0] d, input logic s);
        wait_valid({tag, "_valid"});
        check({tag, "_data"}, out_data, d);
        check({tag, "_sat"}, out_sat, s);
        tick;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        tick;
        tick;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick;

        // basic sum with exact latency
        go(18'h00400, 3, 0);
        check("basic_busy", busy, 1);
        feed(18'h00400);
        feed(18'h00800);
        feed(18'h3FC00);
        check("basic_finish", out_valid, 0);
        tick;
        check("basic_lat", out_valid, 1);
        check("basic_data", out_data, 18'h00C00);
        check("basic_sat", out_sat, 0);
        tick;
        check("basic_pulse", out_valid, 0);
        check("basic_idle", busy, 0);

        go(18'h0, 2, 1);
        feed(18'h3F000);
        feed(18'h00400);
        result("relu_on", 18'h0, 0);
        go(18'h0, 2, 0);
        feed(18'h3F000);
        feed(18'h00400);
        result("relu_off", 18'h3F400, 0);

        go(18'h1FFFF, 4, 0);
        for (int i = 0; i < 4; i++) feed(18'h1FFFF);
        result("sat_hi", 18'h1FFFF, 1);
        go(18'h20000, 4, 0);
        for (int i = 0; i < 4; i++) feed(18'h20000);
        result("sat_lo", 18'h20000, 1);
        go(18'h20000, 1, 1);
        feed(18'h20000);
        result("relu_nosat", 18'h0, 0);

        // gaps, stray start while busy, backpressure
        out_ready = 1'b0;
        go(18'h0, 2, 0);
        feed(18'h00400);
        start = 1'b1;
        n_groups = 5;
        bias = 18'h01000;
        tick;
        start = 1'b0;
        tick;
        tick;
        feed(18'h00800);
        wait_valid("bp_valid");
        held = out_data;
        check("bp_data", held, 18'h00C00);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, held);
        end
        out_ready = 1'b1;
        tick;
        check("bp_idle", busy, 0);
        check("bp_released", out_valid, 0);

        // boundaries: zero groups, stray in_valid, start with in_valid, max groups
        start = 1'b1;
        n_groups = 0;
        tick;
        start = 1'b0;
        check("zero_groups", busy, 0);
        feed(18'h1FFFF);
        check("idle_invalid", busy, 0);
        in_valid = 1'b1;
        in_data = 18'h12345;
        go(18'h0, 15, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) feed(18'h00400);
        result("max_groups", 18'h03C00, 0);

        // async reset mid-accumulation
        go(18'h00400, 3, 0);
        feed(18'h00400);
        feed(18'h00400);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_sat", out_sat, 0);
        tick;
        rst = 1'b0;
        tick;
        go(18'h0, 1, 0);
        feed(18'h00400);
        result("fresh", 18'h00400, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
